// File: rtl/kf8237_service_sequencer.sv
// 8237-style DMA service sequencer: HRQ/HLDA handshake, DACK, S1-S4 transfer timing, EOP, rotation.
// Optional KF8237_COMPRESSED_TIMING_EN: skip S3, and block/demand continue re-enters S2.
module kf8237_service_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_p_en,
  input  logic       clock_n_en,
  input  logic [7:0] internal_data_bus,
  input  logic       write_mode_register,
  input  logic       master_clear,
  input  logic [3:0] encoded_dma,
  input  logic [3:0] dma_request_state,
  input  logic       hold_acknowledge,
  input  logic       terminal_count,
  input  logic       end_of_process_external,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge_internal,
  output logic       transfer_strobe,
  output logic       end_of_process_internal,
  output logic [1:0] dma_rotate
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4, SC} state_t;

  localparam logic [1:0] M_DEMAND  = 2'b00;
  localparam logic [1:0] M_SINGLE  = 2'b01;
  localparam logic [1:0] M_BLOCK   = 2'b10;
  localparam logic [1:0] M_CASCADE = 2'b11;

`ifdef KF8237_COMPRESSED_TIMING_EN
  localparam state_t S_AFTER_S2 = S4;
  localparam state_t S_CONT     = S2;
`else
  localparam state_t S_AFTER_S2 = S3;
  localparam state_t S_CONT     = S1;
`endif

  state_t          r_state, w_next;
  logic [1:0]      r_ch;
  logic [3:0][1:0] r_mode;
  logic            r_hrq, r_eop_seen;
  logic [3:0]      r_dack;
  logic [1:0]      r_rotate;
  logic [1:0]      w_enc_idx, w_mode;
  logic            w_strobe, w_eop, w_abort, w_done, w_step, w_in_xfer;

  assign w_mode    = r_mode[r_ch];
  assign w_done    = terminal_count | r_eop_seen;
  assign w_step    = clock_p_en & ~master_clear;
  assign w_in_xfer = (r_state == S1) | (r_state == S2) | (r_state == S3) | (r_state == S4);

  always_comb begin
    w_enc_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (encoded_dma[i]) w_enc_idx = 2'(i);
  end

  // Next state assuming a p-step occurs; strobe/EOP are gated by the step itself.
  always_comb begin
    w_next   = r_state;
    w_strobe = 1'b0;
    w_eop    = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      SI: if (encoded_dma != 4'd0) w_next = S0;
      S0: begin
        if (hold_acknowledge)
          w_next = (w_mode == M_CASCADE) ? SC : S1;
        else if (encoded_dma == 4'd0) begin
          w_next  = SI;
          w_abort = 1'b1;
        end
      end
      S1: w_next = S2;
      S2: w_next = S_AFTER_S2;
      S3: w_next = S4;
      S4: begin
        w_strobe = 1'b1;
        if (w_done) begin
          w_eop  = 1'b1;
          w_next = SI;
        end else if (!hold_acknowledge)
          w_next = SI;
        else case (w_mode)
          M_DEMAND: w_next = dma_request_state[r_ch] ? S_CONT : SI;
          M_BLOCK:  w_next = S_CONT;
          default:  w_next = SI;
        endcase
      end
      SC: if (!dma_request_state[r_ch] || !hold_acknowledge) w_next = SI;
      default: w_next = SI;
    endcase
  end

  assign transfer_strobe          = w_step & w_strobe;
  assign end_of_process_internal  = w_step & w_eop;
  assign hold_request             = r_hrq;
  assign dma_acknowledge_internal = r_dack;
  assign dma_rotate               = r_rotate;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= SI;
      r_ch       <= 2'd0;
      r_mode     <= '0;
      r_hrq      <= 1'b0;
      r_dack     <= 4'd0;
      r_rotate   <= 2'd0;
      r_eop_seen <= 1'b0;
    end else if (master_clear) begin
      r_state    <= SI;
      r_hrq      <= 1'b0;
      r_dack     <= 4'd0;
      r_rotate   <= 2'd0;
      r_eop_seen <= 1'b0;
    end else begin
      if (write_mode_register)
        r_mode[internal_data_bus[1:0]] <= internal_data_bus[7:6];
      if (clock_n_en && w_in_xfer && end_of_process_external)
        r_eop_seen <= 1'b1;
      if (clock_p_en) begin
        r_state <= w_next;
        if (r_state == SI && w_next == S0) begin
          r_ch  <= w_enc_idx;
          r_hrq <= 1'b1;
        end
        if (r_state == S0 && (w_next == S1 || w_next == SC))
          r_dack <= 4'b0001 << r_ch;
        // Leaving service: the served channel becomes lowest priority (not on S0 abort).
        if (r_state != SI && w_next == SI) begin
          r_hrq      <= 1'b0;
          r_dack     <= 4'd0;
          r_eop_seen <= 1'b0;
          if (!w_abort) r_rotate <= r_ch + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kf8237_service_sequencer.sv
// Scenario bench for kf8237_service_sequencer; strobe/EOP events checked against a scoreboard queue.
module tb_kf8237_service_sequencer;

`ifdef KF8237_COMPRESSED_TIMING_EN
  localparam int FIRST = 2;  // p-steps from DACK to being in the first S4
  localparam int NEXT  = 2;  // p-steps from one S4 to the next on continue
`else
  localparam int FIRST = 3;
  localparam int NEXT  = 4;
`endif

  logic       clock = 1'b0, reset = 1'b1;
  logic       clock_p_en = 1'b0, clock_n_en = 1'b1;
  logic [7:0] internal_data_bus = '0;
  logic       write_mode_register = 1'b0, master_clear = 1'b0;
  logic [3:0] encoded_dma = '0, dma_request_state = '0;
  logic       hold_acknowledge = 1'b0, terminal_count = 1'b0, end_of_process_external = 1'b0;
  logic       hold_request, transfer_strobe, end_of_process_internal;
  logic [3:0] dma_acknowledge_internal;
  logic [1:0] dma_rotate;

  kf8237_service_sequencer dut (
    .clock(clock), .reset(reset), .clock_p_en(clock_p_en), .clock_n_en(clock_n_en),
    .internal_data_bus(internal_data_bus), .write_mode_register(write_mode_register),
    .master_clear(master_clear), .encoded_dma(encoded_dma), .dma_request_state(dma_request_state),
    .hold_acknowledge(hold_acknowledge), .terminal_count(terminal_count),
    .end_of_process_external(end_of_process_external), .hold_request(hold_request),
    .dma_acknowledge_internal(dma_acknowledge_internal), .transfer_strobe(transfer_strobe),
    .end_of_process_internal(end_of_process_internal), .dma_rotate(dma_rotate)
  );

  always #5 clock = ~clock;

  // p-phase and n-phase enables alternate every clock.
  always @(posedge clock) begin
    #2;
    clock_p_en = ~clock_p_en;
    clock_n_en = ~clock_p_en;
  end

  typedef struct packed { logic eop; logic [3:0] dack; } ev_t;
  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0;

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && transfer_strobe === 1'b1) || (k == 1 && end_of_process_internal === 1'b1)) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event eop=%0d got dack=%b required none", k, dma_acknowledge_internal);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.eop !== 1'(k) || e.dack !== dma_acknowledge_internal) begin
              n_fail++;
              $display("FAIL event got eop=%0d dack=%b required eop=%0d dack=%b",
                       k, dma_acknowledge_internal, e.eop, e.dack);
            end
          end
        end
      end
    end
  end

  task automatic wait_p(input int n);
    repeat (n) begin
      do @(posedge clock); while (!clock_p_en);
    end
    #1;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    internal_data_bus   = {m, 4'b0000, 2'(ch)};
    write_mode_register = 1'b1;
    @(posedge clock); #1;
    write_mode_register = 1'b0;
  endtask

  task automatic start(input int ch);
    encoded_dma       = 4'(1 << ch);
    dma_request_state = 4'(1 << ch);
    wait_p(1);
    n_tests++;
    if (hold_request !== 1'b1) begin
      n_fail++; $display("FAIL hrq_latency got %b required 1", hold_request);
    end
    hold_acknowledge = 1'b1;
    wait_p(1);
    n_tests++;
    if (dma_acknowledge_internal !== 4'(1 << ch)) begin
      n_fail++; $display("FAIL dack_latency got %b required %b", dma_acknowledge_internal, 4'(1 << ch));
    end
    encoded_dma = 4'd0;
  endtask

  task automatic wait_idle(input logic [1:0] rot);
    int k = 0;
    while (hold_request !== 1'b0 && k < 60) begin
      wait_p(1);
      k++;
    end
    n_tests++;
    if (hold_request !== 1'b0) begin
      n_fail++; $display("FAIL idle_timeout got hrq=%b required 0", hold_request);
    end
    n_tests++;
    if (dma_acknowledge_internal !== 4'd0 || dma_rotate !== rot) begin
      n_fail++;
      $display("FAIL end_state got dack=%b rotate=%0d required dack=0000 rotate=%0d",
               dma_acknowledge_internal, dma_rotate, rot);
    end
    hold_acknowledge  = 1'b0;
    dma_request_state = 4'd0;
    wait_p(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_events got %0d pending required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    n_tests++;
    if (hold_request !== 1'b0 || dma_acknowledge_internal !== 4'd0 || transfer_strobe !== 1'b0 ||
        end_of_process_internal !== 1'b0 || dma_rotate !== 2'd0) begin
      n_fail++;
      $display("FAIL reset got hrq=%b dack=%b stb=%b eop=%b rot=%0d required all 0",
               hold_request, dma_acknowledge_internal, transfer_strobe, end_of_process_internal, dma_rotate);
    end
  endtask

  task automatic test_single();
    set_mode(2, 2'b01);
    encoded_dma       = 4'b0100;
    dma_request_state = 4'b0100;
    wait_p(1);
    n_tests++;
    if (hold_request !== 1'b1) begin
      n_fail++; $display("FAIL single_hrq got %b required 1", hold_request);
    end
    wait_p(1);
    n_tests++;
    if (dma_acknowledge_internal !== 4'd0) begin
      n_fail++; $display("FAIL single_no_dack got %b required 0000", dma_acknowledge_internal);
    end
    hold_acknowledge = 1'b1;
    exp_q.push_back('{eop: 1'b0, dack: 4'b0100});
    wait_p(1);
    n_tests++;
    if (dma_acknowledge_internal !== 4'b0100) begin
      n_fail++; $display("FAIL single_dack got %b required 0100", dma_acknowledge_internal);
    end
    encoded_dma = 4'd0;
    wait_idle(2'd3);
  endtask

  task automatic test_block_tc();
    set_mode(0, 2'b10);
    start(0);
    repeat (3) exp_q.push_back('{eop: 1'b0, dack: 4'b0001});
    exp_q.push_back('{eop: 1'b1, dack: 4'b0001});
    wait_p(FIRST + 2 * NEXT);
    terminal_count = 1'b1;
    wait_p(1);
    terminal_count = 1'b0;
    wait_idle(2'd1);
  endtask

  task automatic test_demand();
    set_mode(1, 2'b00);
    start(1);
    repeat (2) exp_q.push_back('{eop: 1'b0, dack: 4'b0010});
    wait_p(FIRST + 1);
    dma_request_state = 4'd0;
    wait_idle(2'd2);
  endtask

  task automatic test_ext_eop();
    set_mode(3, 2'b10);
    start(3);
    exp_q.push_back('{eop: 1'b0, dack: 4'b1000});
    exp_q.push_back('{eop: 1'b1, dack: 4'b1000});
    wait_p(1);
    end_of_process_external = 1'b1;  // in S2, next edge is an n-phase edge
    @(posedge clock); #1;
    end_of_process_external = 1'b0;
    wait_idle(2'd0);
  endtask

  task automatic test_cascade();
    set_mode(1, 2'b11);
    start(1);
    wait_p(6);
    n_tests++;
    if (dma_acknowledge_internal !== 4'b0010 || hold_request !== 1'b1) begin
      n_fail++;
      $display("FAIL cascade_hold got dack=%b hrq=%b required 0010 1", dma_acknowledge_internal, hold_request);
    end
    dma_request_state = 4'd0;
    wait_idle(2'd2);
  endtask

  task automatic test_abort();
    encoded_dma       = 4'b0100;
    dma_request_state = 4'b0100;
    wait_p(1);
    n_tests++;
    if (hold_request !== 1'b1) begin
      n_fail++; $display("FAIL abort_hrq got %b required 1", hold_request);
    end
    encoded_dma = 4'd0;
    wait_p(1);
    n_tests++;
    if (hold_request !== 1'b0 || dma_rotate !== 2'd2) begin
      n_fail++; $display("FAIL abort got hrq=%b rot=%0d required 0 2", hold_request, dma_rotate);
    end
    dma_request_state = 4'd0;
  endtask

  task automatic test_master_clear();
    start(2);
    master_clear = 1'b1;
    @(posedge clock); #1;
    master_clear = 1'b0;
    n_tests++;
    if (hold_request !== 1'b0 || dma_acknowledge_internal !== 4'd0 || dma_rotate !== 2'd0) begin
      n_fail++;
      $display("FAIL master_clear got hrq=%b dack=%b rot=%0d required 0 0000 0",
               hold_request, dma_acknowledge_internal, dma_rotate);
    end
    hold_acknowledge = 1'b0;
    wait_p(1);
    // Mode 01 for ch2 must survive master_clear: exactly one strobe.
    start(2);
    exp_q.push_back('{eop: 1'b0, dack: 4'b0100});
    wait_idle(2'd3);
  endtask

  task automatic test_async_reset();
    start(0);
    wait_p(FIRST - 1);
    reset = 1'b1;
    #1;
    n_tests++;
    if (hold_request !== 1'b0 || dma_acknowledge_internal !== 4'd0 || dma_rotate !== 2'd0 ||
        transfer_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got hrq=%b dack=%b rot=%0d stb=%b required 0 0000 0 0",
               hold_request, dma_acknowledge_internal, dma_rotate, transfer_strobe);
    end
    hold_acknowledge  = 1'b0;
    dma_request_state = 4'd0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    wait_p(1);
    test_single();
    test_block_tc();
    test_demand();
    test_ext_eop();
    test_cascade();
    test_abort();
    test_master_clear();
    test_async_reset();
    wait_p(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got still running required finished");
    $fatal(1, "timeout");
  end

endmodule
